key_input_reader: RTL and testbench
===================================

// Module: key_input_reader
// PURPOSE
//  Avalon-MM slave on the system bus that the CPU reads to get push-button state.
//  - Synchronises and debounces WIDTH active-low keys.
//  - Latches debounced press events in a write-one-to-clear edge register.
//  - Raises a maskable level interrupt.
//  Board input path; the CPU-read counterpart to the write-only display peripherals.
// PARAMETERS
//  WIDTH            4      number of keys (1..32)
//  DEBOUNCE_CYCLES  50000  consecutive stable clk cycles to accept a change (>=2; 1 ms @ 50 MHz)
// PORTS
//  clk         in   1      system clock; all logic on its rising edge
//  reset_n     in   1      asynchronous active-low reset
//  chipselect  in   1      Avalon slave select
//  address     in   2      word register select
//  read        in   1      read strobe (valid with chipselect)
//  write       in   1      write strobe (valid with chipselect)
//  writedata   in   32     write data; only [WIDTH-1:0] used
//  readdata    out  32     registered read data; bits above WIDTH read 0
//  irq         out  1      level interrupt, active high
//  keys_n      in   WIDTH  raw keys, asynchronous, 0 = pressed
// BEHAVIOUR
//  Reset values
//  - readdata=0, irq=0, irq_mask=0, edge_cap=0.
//  - Sync flops and stable=all 1s (released); debounce counters=0.
//  - Reset mid-debounce discards partial counts.
//  Sync
//  - 2-flop synchroniser per key -> sync[i].
//  Debounce (per key, independent)
//  - Counter width $clog2(DEBOUNCE_CYCLES).
//  - sync[i]==stable[i]: counter cleared.
//  - sync[i]!=stable[i]: counter increments.
//  - On the cycle the counter equals DEBOUNCE_CYCLES-1 while still differing:
//    stable[i]<=sync[i], counter cleared.
//  - Any glitch back to stable[i] before that restarts the count from 0.
//  - Latency keys_n edge -> stable change = 2 + DEBOUNCE_CYCLES clk edges.
//  Edge capture
//  - Set: edge_cap[i] sets on the cycle stable[i] goes 1->0 (press).
//    Release (0->1) sets nothing.
//  - Clear: write to address 3 clears bits where writedata[i]=1; 0-bits untouched.
//  - Same cycle set and clear on one bit: set wins (no lost press).
//  Register map (reads)
//  - 0: pressed = ~stable, RO.
//  - 1: ~sync (undebounced), RO.
//  - 2: irq_mask, RW.
//  - 3: edge_cap, read / W1C.
//  - Writes to addresses 0 and 1 are ignored.
//  Read timing
//  - chipselect&&read sampled at edge N -> readdata valid after edge N (1-cycle read latency).
//  - Cycles with no read drive readdata to 0.
//  - Read and write in the same cycle: read returns the pre-write value.
//  irq
//  - Registered: irq <= |(edge_cap & irq_mask), so it follows register changes by 1 cycle.
//  - Stays high until the CPU clears edge_cap or the mask.
// TESTING (bench uses WIDTH=4, DEBOUNCE_CYCLES=4)
//  1) Reset.
//     - Assert reset_n=0 mid-run -> readdata=0, irq=0.
//     - Read addr0 after release -> 0x0; read addr3 -> 0x0.
//  2) Clean press.
//     - keys_n=4'b1110 held -> addr0 reads 0x1 after 6 edges (not before).
//     - addr3 reads 0x1.
//  3) Bounce rejection.
//     - keys_n[1] toggles every 2 cycles for 20 cycles, then returns to 1.
//     - Expect: addr0 stays 0x0, addr3 stays 0x0; addr1 shows the toggles.
//  4) IRQ and W1C.
//     - Write addr2=0x2; press key1 -> irq=1.
//     - Write addr3=0x1 -> irq stays 1, edge_cap=0x2.
//     - Write addr3=0x2 -> edge_cap=0x0, irq=0 one cycle later.
//  5) Set/clear collision.
//     - Write addr3=0x4 on the cycle stable[2] falls -> edge_cap[2] reads 1.
//  6) Release and multiple keys.
//     - Press keys 0 and 3 together -> edge_cap=0x9.
//     - Release both -> edge_cap unchanged 0x9, addr0=0x0.

Source files
------------

// File: rtl/key_input_reader_if.sv
// ============================================================================
// key_input_reader_if : Avalon-MM slave bus bundle for the key input reader
// Rev 1.0
// ============================================================================
`default_nettype none

interface key_input_reader_if;
   logic        chipselect;
   logic [1:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output chipselect, address, read, write, writedata,
      input  readdata, irq
   );

   modport slave (
      input  chipselect, address, read, write, writedata,
      output readdata, irq
   );
endinterface

`default_nettype wire

// File: rtl/key_input_reader.sv
// ============================================================================
// key_input_reader : debounced push-button reader with W1C press latch and IRQ
// Rev 1.0
// ============================================================================
`default_nettype none

module key_input_reader #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                 clk,
   input  logic                 reset_n,
   key_input_reader_if.slave    bus,
   input  logic [WIDTH-1:0]     keys_n
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ADDR_PRESSED = 2'd0;
   localparam logic [1:0] ADDR_RAW     = 2'd1;
   localparam logic [1:0] ADDR_MASK    = 2'd2;
   localparam logic [1:0] ADDR_EDGE    = 2'd3;

   logic [WIDTH-1:0] sync_meta;
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] press;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] cap_clear;
   logic [31:0]      read_word;
   logic [31:0]      readdata;
   logic             irq;
   logic             wr_en;
   logic             rd_en;

   // Released (1) is the idle level, so the synchroniser resets high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta <= '1;
         sync      <= '1;
      end else begin
         sync_meta <= keys_n;
         sync      <= sync_meta;
      end
   end

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_key
         logic [CNT_W-1:0] count;
         logic             stable_q;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               count    <= '0;
               stable_q <= 1'b1;
            end else if (sync[i] == stable_q) begin
               count <= '0;
            end else if (count == CNT_LAST) begin
               count    <= '0;
               stable_q <= sync[i];
            end else begin
               count <= count + CNT_W'(1);
            end
         end

         assign stable[i] = stable_q;
         // A press is the accepting edge of a 1->0 transition of the debounced level.
         assign press[i]  = stable_q && !sync[i] && (count == CNT_LAST);
      end
   endgenerate

   assign wr_en     = bus.chipselect && bus.write;
   assign rd_en     = bus.chipselect && bus.read;
   assign cap_clear = (wr_en && (bus.address == ADDR_EDGE)) ? bus.writedata[WIDTH-1:0] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= '0;
         edge_cap <= '0;
         irq      <= 1'b0;
      end else begin
         if (wr_en && (bus.address == ADDR_MASK)) begin
            irq_mask <= bus.writedata[WIDTH-1:0];
         end
         // OR-ing press after the clear lets a same-cycle press win over W1C.
         edge_cap <= (edge_cap & ~cap_clear) | press;
         irq      <= |(edge_cap & irq_mask);
      end
   end

   always_comb begin
      read_word = '0;
      case (bus.address)
         ADDR_PRESSED: read_word[WIDTH-1:0] = ~stable;
         ADDR_RAW:     read_word[WIDTH-1:0] = ~sync;
         ADDR_MASK:    read_word[WIDTH-1:0] = irq_mask;
         ADDR_EDGE:    read_word[WIDTH-1:0] = edge_cap;
         default:      read_word            = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= rd_en ? read_word : '0;
      end
   end

   assign bus.readdata = readdata;
   assign bus.irq      = irq;

   generate
      if (WIDTH < 32) begin : g_spare
         logic unused_writedata_hi;
         assign unused_writedata_hi = ^bus.writedata[31:WIDTH];
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_key_input_reader.sv
// ============================================================================
// tb_key_input_reader : directed + random bench with a window-based key model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_key_input_reader;

   localparam int WIDTH = 4;
   localparam int DC    = 4;

   logic             clk     = 1'b0;
   logic             reset_n = 1'b0;
   logic [WIDTH-1:0] keys_n  = '1;

   key_input_reader_if bus();

   key_input_reader #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .keys_n  (keys_n)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: a key's accepted level flips once the last DC
   // synchronised observations all disagree with it.
   logic [WIDTH-1:0] m_s1, m_s2, m_stable, m_cap, m_mask;
   logic [WIDTH-1:0] m_win [DC];
   logic [31:0]      m_rd;
   logic             m_irq;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_s1     = '1;
      m_s2     = '1;
      m_stable = '1;
      m_cap    = '0;
      m_mask   = '0;
      m_rd     = '0;
      m_irq    = 1'b0;
      for (int j = 0; j < DC; j++) m_win[j] = '1;
   endtask

   task automatic model_step();
      logic [WIDTH-1:0] nstable;
      logic [WIDTH-1:0] pressed_now;
      logic [31:0]      rd;
      bit               all_differ;
      for (int j = DC - 1; j > 0; j--) m_win[j] = m_win[j-1];
      m_win[0] = m_s2;
      nstable = m_stable;
      for (int i = 0; i < WIDTH; i++) begin
         all_differ = 1'b1;
         for (int j = 0; j < DC; j++)
            if (m_win[j][i] == m_stable[i]) all_differ = 1'b0;
         if (all_differ) nstable[i] = ~m_stable[i];
      end
      pressed_now = m_stable & ~nstable;
      rd = '0;
      if (bus.chipselect && bus.read) begin
         case (bus.address)
            2'd0: rd[WIDTH-1:0] = ~m_stable;
            2'd1: rd[WIDTH-1:0] = ~m_s2;
            2'd2: rd[WIDTH-1:0] = m_mask;
            default: rd[WIDTH-1:0] = m_cap;
         endcase
      end
      m_rd  = rd;
      m_irq = |(m_cap & m_mask);
      if (bus.chipselect && bus.write) begin
         if (bus.address == 2'd2) m_mask = bus.writedata[WIDTH-1:0];
         if (bus.address == 2'd3) m_cap  = m_cap & ~bus.writedata[WIDTH-1:0];
      end
      m_cap    = m_cap | pressed_now;
      m_stable = nstable;
      m_s2     = m_s1;
      m_s1     = keys_n;
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset_n) model_step();
      @(negedge clk);
      check("model_readdata", bus.readdata, m_rd);
      check("model_irq", {31'b0, bus.irq}, {31'b0, m_irq});
   endtask

   task automatic idle(input int n);
      bus.chipselect = 1'b0;
      bus.read       = 1'b0;
      bus.write      = 1'b0;
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.write      = 1'b0;
      bus.address    = a;
      tick();
      check(tag, bus.readdata, exp);
      bus.chipselect = 1'b0;
      bus.read       = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.chipselect = 1'b1;
      bus.read       = 1'b0;
      bus.write      = 1'b1;
      bus.address    = a;
      bus.writedata  = d;
      tick();
      bus.chipselect = 1'b0;
      bus.write      = 1'b0;
   endtask

   initial begin
      logic saw_toggle;
      bus.chipselect = 1'b0;
      bus.read       = 1'b0;
      bus.write      = 1'b0;
      bus.address    = 2'd0;
      bus.writedata  = '0;
      model_reset();
      idle(3);
      reset_n = 1'b1;

      // Reset state
      rd(2'd0, 32'h0, "reset_pressed");
      rd(2'd3, 32'h0, "reset_edge");

      // Clean press on key 0: visible to a read issued on the 7th edge only
      keys_n = 4'b1110;
      for (int k = 1; k <= 7; k++) rd(2'd0, (k == 7) ? 32'h1 : 32'h0, "press_latency");
      rd(2'd3, 32'h1, "press_edge");

      // Bounce rejection on key 1
      keys_n = 4'b1111;
      idle(8);
      wr(2'd3, 32'hF);
      rd(2'd3, 32'h0, "bounce_pre_clear");
      saw_toggle = 1'b0;
      for (int c = 0; c < 20; c++) begin
         keys_n[1] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
         bus.chipselect = 1'b1;
         bus.read       = 1'b1;
         bus.address    = 2'd1;
         tick();
         if (bus.readdata[1]) saw_toggle = 1'b1;
      end
      check("bounce_raw_seen", {31'b0, saw_toggle}, 32'h1);
      keys_n[1] = 1'b1;
      idle(6);
      rd(2'd0, 32'h0, "bounce_pressed");
      rd(2'd3, 32'h0, "bounce_edge");

      // IRQ and write-one-to-clear
      wr(2'd2, 32'h2);
      keys_n = 4'b1101;
      idle(8);
      check("irq_on_press", {31'b0, bus.irq}, 32'h1);
      wr(2'd3, 32'h1);
      check("irq_other_clear", {31'b0, bus.irq}, 32'h1);
      rd(2'd3, 32'h2, "edge_after_w1c_other");
      wr(2'd3, 32'h2);
      check("irq_lag_after_clear", {31'b0, bus.irq}, 32'h1);
      rd(2'd3, 32'h0, "edge_cleared");
      check("irq_cleared", {31'b0, bus.irq}, 32'h0);
      keys_n = 4'b1111;
      idle(8);

      // Set/clear collision on key 2: the W1C lands on the accepting edge
      keys_n = 4'b1011;
      idle(5);
      wr(2'd3, 32'h4);
      rd(2'd3, 32'h4, "collision_set_wins");
      keys_n = 4'b1111;
      idle(8);
      wr(2'd3, 32'hF);
      rd(2'd3, 32'h0, "collision_cleanup");

      // Multiple keys, then release
      keys_n = 4'b0110;
      idle(8);
      rd(2'd3, 32'h9, "multi_edge");
      rd(2'd0, 32'h9, "multi_pressed");
      keys_n = 4'b1111;
      idle(8);
      rd(2'd3, 32'h9, "release_edge_kept");
      rd(2'd0, 32'h0, "release_pressed");

      // Reset mid-run with an outstanding read, a pending IRQ and a partial debounce
      wr(2'd2, 32'hF);
      idle(2);
      check("pre_reset_irq", {31'b0, bus.irq}, 32'h1);
      keys_n = 4'b1110;
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.address    = 2'd3;
      tick();
      check("pre_reset_read", bus.readdata, 32'h9);
      tick();
      reset_n = 1'b0;
      model_reset();
      #1;
      check("reset_readdata", bus.readdata, 32'h0);
      check("reset_irq", {31'b0, bus.irq}, 32'h0);
      idle(2);
      reset_n = 1'b1;
      rd(2'd0, 32'h0, "post_reset_pressed");
      rd(2'd3, 32'h0, "post_reset_edge");
      rd(2'd2, 32'h0, "post_reset_mask");
      idle(8);
      rd(2'd0, 32'h1, "post_reset_repress");

      // Randomised traffic against the model
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < WIDTH; i++)
            if ($urandom_range(0, 7) == 0) keys_n[i] = ~keys_n[i];
         bus.chipselect = ($urandom_range(0, 3) != 0);
         bus.read       = $urandom_range(0, 1) == 1;
         bus.write      = ($urandom_range(0, 3) == 0);
         bus.address    = 2'($urandom_range(0, 3));
         bus.writedata  = $urandom;
         tick();
      end
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
